// File: rtl/ascon_enc_host_if.sv
// Byte-lane register bus between the host initiator and the SocEncryption core.
interface ascon_enc_host_if;
    logic [3:0]  reg_inputxSS;
    logic [31:0] inputxSI;
    logic        reg_startxSS;
    logic        encryption_startxSI;
    logic        encryption_readyxSO;
    logic        reg_outxSS;
    logic [7:0]  cipher_tagxSO;

    modport master (
        output reg_inputxSS, inputxSI, reg_startxSS, encryption_startxSI, reg_outxSS,
        input  encryption_readyxSO, cipher_tagxSO
    );

    modport slave (
        input  reg_inputxSS, inputxSI, reg_startxSS, encryption_startxSI, reg_outxSS,
        output encryption_readyxSO, cipher_tagxSO
    );
endinterface

// File: rtl/ascon_enc_host.sv
// Host initiator: loads key/nonce/AD/PT byte lanes, starts the core, collects CT+tag.
// Optional ready watchdog enabled by defining ASCON_HOST_TIMEOUT_EN.
module ascon_enc_host #(
    parameter int K         = 128,
    parameter int L         = 40,
    parameter int Y         = 40,
    parameter int START_CYC = 2,
    parameter int OUT_DELAY = 3,
    parameter int TIMEOUT   = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_start,
    input  logic [K-1:0]          key_i,
    input  logic [127:0]          nonce_i,
    input  logic [L-1:0]          ad_i,
    input  logic [Y-1:0]          pt_i,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [Y-1:0]          ct_o,
    output logic [127:0]          tag_o,
    output logic [31:0]           cycles_o,
    ascon_enc_host_if.master      soc
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXL = max2(max2(K, 128), max2(L, Y));
    localparam int NWR  = MAXL / 8;
    localparam int NRD  = Y / 8 + 16;
    localparam int NCT  = Y / 8;
    localparam int CMAX = max2(max2(NWR, NRD), max2(START_CYC, OUT_DELAY));
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_OSEL, S_READ, S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [MAXL-1:0] key_sr_reg, nonce_sr_reg, ad_sr_reg, pt_sr_reg;
    logic [Y-1:0]    ct_reg;
    logic [127:0]    tag_reg;
    logic [31:0]     cycles_reg;

    logic capture, load_shift, cyc_clear, cyc_inc, rd_ct, rd_tag, timeout_hit;

`ifdef ASCON_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wdog_reg;
    logic          err_reg;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        capture     = 1'b0;
        load_shift  = 1'b0;
        cyc_clear   = 1'b0;
        cyc_inc     = 1'b0;
        rd_ct       = 1'b0;
        rd_tag      = 1'b0;
        timeout_hit = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        soc.reg_inputxSS        = 4'h0;
        soc.inputxSI            = 32'h0;
        soc.reg_startxSS        = 1'b0;
        soc.encryption_startxSI = 1'b0;
        soc.reg_outxSS          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (op_start) begin
                    capture    = 1'b1;
                    cnt_next   = '0;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy             = 1'b1;
                load_shift       = 1'b1;
                soc.reg_inputxSS = 4'hF;
                // Operands are left-aligned, so the top byte is always lane byte i
                soc.inputxSI = {pt_sr_reg[MAXL-1 -: 8], ad_sr_reg[MAXL-1 -: 8],
                                nonce_sr_reg[MAXL-1 -: 8], key_sr_reg[MAXL-1 -: 8]};
                if (cnt_reg == CW'(NWR - 1)) begin
                    cnt_next   = '0;
                    cyc_clear  = 1'b1;
                    state_next = S_START;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_START: begin
                busy                    = 1'b1;
                cyc_inc                 = 1'b1;
                soc.reg_startxSS        = 1'b1;
                soc.encryption_startxSI = 1'b1;
                if (cnt_reg == CW'(START_CYC - 1)) begin
                    cnt_next   = '0;
                    state_next = S_WAIT;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (soc.encryption_readyxSO) begin
                    cnt_next   = '0;
                    state_next = S_OSEL;
                end else begin
                    cyc_inc = 1'b1;
`ifdef ASCON_HOST_TIMEOUT_EN
                    if (wdog_reg == TW'(TIMEOUT - 1)) begin
                        timeout_hit = 1'b1;
                        state_next  = S_DONE;
                    end
`endif
                end
            end
            S_OSEL: begin
                busy           = 1'b1;
                soc.reg_outxSS = 1'b1;
                if (cnt_reg == CW'(OUT_DELAY - 1)) begin
                    cnt_next   = '0;
                    state_next = S_READ;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (cnt_reg < CW'(NCT)) rd_ct = 1'b1;
                else                    rd_tag = 1'b1;
                if (cnt_reg == CW'(NRD - 1)) begin
                    cnt_next   = '0;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_sr_reg   <= '0;
            nonce_sr_reg <= '0;
            ad_sr_reg    <= '0;
            pt_sr_reg    <= '0;
            ct_reg       <= '0;
            tag_reg      <= '0;
            cycles_reg   <= '0;
        end else begin
            if (capture) begin
                key_sr_reg   <= MAXL'(key_i) << (MAXL - K);
                nonce_sr_reg <= MAXL'(nonce_i) << (MAXL - 128);
                ad_sr_reg    <= MAXL'(ad_i) << (MAXL - L);
                pt_sr_reg    <= MAXL'(pt_i) << (MAXL - Y);
            end else if (load_shift) begin
                key_sr_reg   <= key_sr_reg << 8;
                nonce_sr_reg <= nonce_sr_reg << 8;
                ad_sr_reg    <= ad_sr_reg << 8;
                pt_sr_reg    <= pt_sr_reg << 8;
            end
            if (cyc_clear)
                cycles_reg <= '0;
            else if (cyc_inc && cycles_reg != 32'hFFFF_FFFF)
                cycles_reg <= cycles_reg + 32'd1;
            if (timeout_hit) begin
                ct_reg  <= '0;
                tag_reg <= '0;
            end else begin
                if (rd_ct)  ct_reg  <= (ct_reg << 8) | Y'(soc.cipher_tagxSO);
                if (rd_tag) tag_reg <= (tag_reg << 8) | 128'(soc.cipher_tagxSO);
            end
        end
    end

`ifdef ASCON_HOST_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            wdog_reg <= (state_reg == S_WAIT) ? wdog_reg + TW'(1) : '0;
            if (capture)          err_reg <= 1'b0;
            else if (timeout_hit) err_reg <= 1'b1;
        end
    end
    assign err = err_reg;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign err = 1'b0;
`endif

    assign ct_o     = ct_reg;
    assign tag_o    = tag_reg;
    assign cycles_o = cycles_reg;
endmodule

// File: tb/tb_ascon_enc_host.sv
// Directed bench for ascon_enc_host: load lanes, start/ready timing, read stream, resets, watchdog.
module tb_ascon_enc_host;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         op_start = 1'b0;
    logic [127:0] key_i = '0;
    logic [127:0] nonce_i = '0;
    logic [39:0]  ad_i = '0;
    logic [39:0]  pt_i = '0;
    logic         busy, done, err;
    logic [39:0]  ct_o;
    logic [127:0] tag_o;
    logic [31:0]  cycles_o;
    logic [31:0]  wr [40];
    int           total = 0;
    int           bad = 0;
    int           n, k, nst;

    ascon_enc_host_if bus();

    ascon_enc_host #(.TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .op_start(op_start),
        .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i), .pt_i(pt_i),
        .busy(busy), .done(done), .err(err),
        .ct_o(ct_o), .tag_o(tag_o), .cycles_o(cycles_o),
        .soc(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"},   128'(busy), 128'd0);
        chk({pfx, "_done"},   128'(done), 128'd0);
        chk({pfx, "_err"},    128'(err), 128'd0);
        chk({pfx, "_ct"},     128'(ct_o), 128'd0);
        chk({pfx, "_tag"},    tag_o, 128'd0);
        chk({pfx, "_cyc"},    128'(cycles_o), 128'd0);
        chk({pfx, "_wrs"},    128'(bus.reg_inputxSS), 128'd0);
        chk({pfx, "_wrd"},    128'(bus.inputxSI), 128'd0);
        chk({pfx, "_start"},  128'({bus.reg_startxSS, bus.encryption_startxSI}), 128'd0);
        chk({pfx, "_osel"},   128'(bus.reg_outxSS), 128'd0);
    endtask

    initial begin
        bus.encryption_readyxSO = 1'b0;
        bus.cipher_tagxSO       = 8'h00;

        // Reset held with random inputs
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            op_start = 1'($urandom_range(0, 1));
            bus.encryption_readyxSO = 1'($urandom_range(0, 1));
            bus.cipher_tagxSO = 8'($urandom);
            key_i = {$urandom, $urandom, $urandom, $urandom};
            nonce_i = {$urandom, $urandom, $urandom, $urandom};
            ad_i = {8'($urandom), $urandom};
            pt_i = {8'($urandom), $urandom};
        end
        #1;
        chk_zero("rst");
        @(negedge clk);
        op_start = 1'b0;
        bus.encryption_readyxSO = 1'b0;
        bus.cipher_tagxSO = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 128'(busy), 128'd0);
        chk("idle_wrs", 128'(bus.reg_inputxSS), 128'd0);

        // Operation 1: lane writes
        key_i   = 128'h000102030405060708090A0B0C0D0E0F;
        nonce_i = 128'h101112131415161718191A1B1C1D1E1F;
        ad_i    = 40'h3031323334;
        pt_i    = 40'h4041424344;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        chk("load_busy", 128'(busy), 128'd1);
        n = 0;
        while (bus.reg_inputxSS == 4'hF && n < 40) begin
            wr[n] = bus.inputxSI;
            n++;
            @(negedge clk);
        end
        chk("nwr", 128'(n), 128'd16);
        chk("wr0", 128'(wr[0]), 128'h40301000);
        chk("wr5", 128'(wr[5]), 128'h00001505);
        chk("wr15", 128'(wr[15]), 128'h00001F0F);
        chk("post_load_wrd", 128'(bus.inputxSI), 128'd0);

        // Start strobe, ready 37 cycles after the first start cycle, op_start re-pulsed in WAIT
        k = 0;
        nst = 0;
        while (!bus.reg_outxSS && k < 300) begin
            if (bus.reg_startxSS && bus.encryption_startxSI) nst++;
            op_start = (k == 10);
            if (k == 37) bus.encryption_readyxSO = 1'b1;
            k++;
            @(negedge clk);
        end
        op_start = 1'b0;
        bus.encryption_readyxSO = 1'b0;
        chk("start_len", 128'(nst), 128'd2);
        chk("osel_at", 128'(k), 128'd38);
        chk("cycles37", 128'(cycles_o), 128'd37);

        n = 0;
        while (bus.reg_outxSS && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("osel_len", 128'(n), 128'd3);

        // Read stream 01..15
        n = 0;
        while (!done && n < 60) begin
            bus.cipher_tagxSO = 8'(n + 1);
            n++;
            @(negedge clk);
        end
        chk("read_len", 128'(n), 128'd21);
        chk("done_hi", 128'(done), 128'd1);
        chk("done_busy", 128'(busy), 128'd0);
        chk("ct1", 128'(ct_o), 128'h0102030405);
        chk("tag1", tag_o, 128'h060708090A0B0C0D0E0F101112131415);
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'd0);
        chk("repulse_ignored", 128'(busy), 128'd0);
        chk("ct1_hold", 128'(ct_o), 128'h0102030405);
        chk("cyc1_hold", 128'(cycles_o), 128'd37);

        // Operation 2: ready high throughout (ignored in LOAD/START), reset mid-READ
        op_start = 1'b1;
        bus.encryption_readyxSO = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        n = 0;
        while (!bus.reg_outxSS && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("osel2_seen", 128'(bus.reg_outxSS), 128'd1);
        chk("cycles2", 128'(cycles_o), 128'd2);
        bus.encryption_readyxSO = 1'b0;
        n = 0;
        while (bus.reg_outxSS && n < 20) begin
            n++;
            @(negedge clk);
        end
        for (int b = 0; b < 5; b++) begin
            bus.cipher_tagxSO = 8'(8'h50 + b);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk_zero("midrd");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_no_done", 128'(done), 128'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Operation 3: recovery after reset
        op_start = 1'b1;
        bus.encryption_readyxSO = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        n = 0;
        while (!bus.reg_outxSS && n < 100) begin
            n++;
            @(negedge clk);
        end
        bus.encryption_readyxSO = 1'b0;
        n = 0;
        while (bus.reg_outxSS && n < 20) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (!done && n < 60) begin
            bus.cipher_tagxSO = 8'(8'hA0 + n);
            n++;
            @(negedge clk);
        end
        chk("read3_len", 128'(n), 128'd21);
        chk("ct3", 128'(ct_o), 128'hA0A1A2A3A4);
        chk("tag3", tag_o, 128'hA5A6A7A8A9AAABACADAEAFB0B1B2B3B4);
        chk("err3", 128'(err), 128'd0);
        @(negedge clk);

`ifdef ASCON_HOST_TIMEOUT_EN
        // Operation 4: ready never arrives, watchdog fires after 100 WAIT cycles
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        n = 0;
        while (!bus.reg_startxSS && n < 100) begin
            n++;
            @(negedge clk);
        end
        while (bus.reg_startxSS && n < 200) begin
            n++;
            @(negedge clk);
        end
        k = 0;
        while (!done && k < 500) begin
            k++;
            @(negedge clk);
        end
        chk("to_at", 128'(k), 128'd100);
        chk("to_err", 128'(err), 128'd1);
        chk("to_ct", 128'(ct_o), 128'd0);
        chk("to_tag", tag_o, 128'd0);
        @(negedge clk);
        chk("to_err_sticky", 128'(err), 128'd1);
        chk("to_done_pulse", 128'(done), 128'd0);
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        chk("err_cleared", 128'(err), 128'd0);
        chk("to_busy_again", 128'(busy), 128'd1);
`else
        chk("err_tied", 128'(err), 128'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
